// File: rtl/dvsd_cmp_pkg.sv
// Shared encodings and sizing helper for the bit-serial magnitude comparator.
package dvsd_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DEC_EQ = 2'd0,
    DEC_LT = 2'd1,
    DEC_GT = 2'd2
  } dec_e;

  // Counter must hold WIDTH itself, hence WIDTH+1 codes.
  function automatic int ctr_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/dvsd_cmp_bit_ctr.sv
// Beat counter: clear on start, count accepted beats, flag the final beat of a word.
module dvsd_cmp_bit_ctr #(
  parameter int WIDTH = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      clr_i,
  input  logic                                      inc_i,
  output logic [dvsd_cmp_pkg::ctr_width(WIDTH)-1:0] cnt_o,
  output logic                                      term_o
);
  localparam int CW = dvsd_cmp_pkg::ctr_width(WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  // Terminal is qualified by the beat so it marks the WIDTH-th accepted pair.
  assign term_o = inc_i && (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/dvsd_cmp_serial.sv
// Bit-serial MSB-first magnitude comparator with valid/ready bit and result links.
// Define DVSD_CMP_SIGNED_EN to add the signed_in port for two's complement compares.
module dvsd_cmp_serial
  import dvsd_cmp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_in,
  input  logic a_bit_in,
  input  logic b_bit_in,
  input  logic bit_valid_in,
`ifdef DVSD_CMP_SIGNED_EN
  input  logic signed_in,
`endif
  output logic bit_ready_out,
  output logic result_valid_out,
  input  logic result_ready_in,
  output logic less_than,
  output logic equal_to,
  output logic greater_than,
  output logic busy_out
);
  localparam int CW = ctr_width(WIDTH);

  state_e        state_q;
  dec_e          dec_q, dec_d;
  logic          lt_q, eq_q, gt_q, valid_q, signed_q;
  logic          signed_sel;
  logic          beat, start_acc, term, msb_beat, a_wins;
  logic [CW-1:0] cnt;

`ifdef DVSD_CMP_SIGNED_EN
  assign signed_sel = signed_in;
`else
  assign signed_sel = 1'b0;
`endif

  assign beat      = bit_valid_in && (state_q == ST_SHIFT);
  assign start_acc = start_in && ((state_q == ST_IDLE) ||
                                  (state_q == ST_HOLD && result_ready_in));
  assign msb_beat  = (cnt == '0);
  // A sign-bit difference favours the operand carrying the 0.
  assign a_wins    = a_bit_in ^ (signed_q && msb_beat);

  always_comb begin
    dec_d = dec_q;
    if (dec_q == DEC_EQ && (a_bit_in != b_bit_in))
      dec_d = a_wins ? DEC_GT : DEC_LT;
  end

  dvsd_cmp_bit_ctr #(.WIDTH(WIDTH)) u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (start_acc),
    .inc_i  (beat),
    .cnt_o  (cnt),
    .term_o (term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      dec_q    <= DEC_EQ;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      valid_q  <= 1'b0;
      signed_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            state_q  <= ST_SHIFT;
            dec_q    <= DEC_EQ;
            {lt_q, eq_q, gt_q} <= 3'b000;
            signed_q <= signed_sel;
          end
        end
        ST_SHIFT: begin
          if (beat) begin
            dec_q <= dec_d;
            if (term) begin
              state_q <= ST_HOLD;
              valid_q <= 1'b1;
              lt_q    <= (dec_d == DEC_LT);
              eq_q    <= (dec_d == DEC_EQ);
              gt_q    <= (dec_d == DEC_GT);
            end
          end
        end
        ST_HOLD: begin
          if (result_ready_in) begin
            valid_q <= 1'b0;
            if (start_in) begin
              state_q  <= ST_SHIFT;
              dec_q    <= DEC_EQ;
              {lt_q, eq_q, gt_q} <= 3'b000;
              signed_q <= signed_sel;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bit_ready_out    = (state_q == ST_SHIFT);
  assign busy_out         = (state_q != ST_IDLE);
  assign result_valid_out = valid_q;
  assign less_than        = lt_q;
  assign equal_to         = eq_q;
  assign greater_than     = gt_q;

endmodule

// File: tb/tb_dvsd_cmp_serial.sv
// Scoreboard bench for dvsd_cmp_serial (WIDTH=4); honours DVSD_CMP_SIGNED_EN.
module tb_dvsd_cmp_serial;
  logic clk = 1'b0;
  logic rst_n, start_in, a_bit_in, b_bit_in, bit_valid_in, sgn_drv;
  logic bit_ready_out, result_valid_out, result_ready_in;
  logic less_than, equal_to, greater_than, busy_out;
  logic [2:0] flags;
  logic [2:0] sb_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  dvsd_cmp_serial #(.WIDTH(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_in         (start_in),
    .a_bit_in         (a_bit_in),
    .b_bit_in         (b_bit_in),
    .bit_valid_in     (bit_valid_in),
`ifdef DVSD_CMP_SIGNED_EN
    .signed_in        (sgn_drv),
`endif
    .bit_ready_out    (bit_ready_out),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .less_than        (less_than),
    .equal_to         (equal_to),
    .greater_than     (greater_than),
    .busy_out         (busy_out)
  );

  assign flags = {less_than, equal_to, greater_than};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] model(input logic [3:0] a, input logic [3:0] b, input logic s);
    int ia, ib;
    ia = (s && a[3]) ? int'(a) - 16 : int'(a);
    ib = (s && b[3]) ? int'(b) - 16 : int'(b);
    return {ia < ib, ia == ib, ia > ib};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops one expectation per result handshake.
  always @(negedge clk) begin
    if (rst_n && result_valid_out && result_ready_in) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 8'(sb_q.size()), 8'd1);
      end else begin
        logic [2:0] e;
        e = sb_q.pop_front();
        chk("result", {5'd0, flags}, {5'd0, e});
        $display("result lt/eq/gt=%b expected %b", flags, e);
      end
    end
  end

  task automatic run_word(input logic [3:0] a, input logic [3:0] b, input int gap_at,
                          input int gaps, input logic sgn, input int hold,
                          output logic [2:0] e);
    e = model(a, b, sgn);
    sb_q.push_back(e);
    result_ready_in = (hold == 0);
    start_in = 1'b1;
    sgn_drv  = sgn;
    step();
    start_in = 1'b0;
    chk("shift_entry", {2'b00, bit_ready_out, busy_out, result_valid_out, flags}, 8'b0011_0000);
    for (int i = 3; i >= 0; i--) begin
      if (i == gap_at) begin
        repeat (gaps) begin
          bit_valid_in = 1'b0;
          a_bit_in = ~a[i];
          b_bit_in = a[i];
          step();
        end
      end
      a_bit_in = a[i];
      b_bit_in = b[i];
      bit_valid_in = 1'b1;
      step();
    end
    bit_valid_in = 1'b0;
    chk("latency", {6'd0, result_valid_out, bit_ready_out}, 8'b10);
    for (int k = 0; k < hold; k++) begin
      chk("hold", {2'b00, result_valid_out, bit_ready_out, busy_out, flags}, {5'b00101, e});
      step();
    end
    result_ready_in = 1'b1;
  endtask

  task automatic to_idle(input logic [2:0] e);
    step();
    chk("idle", {5'd0, busy_out, result_valid_out, bit_ready_out}, 8'd0);
    chk("flags_keep", {5'd0, flags}, {5'd0, e});
  endtask

  initial begin
    logic [2:0] e;
    rst_n = 1'b0; start_in = 1'b0; a_bit_in = 1'b0; b_bit_in = 1'b0;
    bit_valid_in = 1'b0; sgn_drv = 1'b0; result_ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {2'b00, bit_ready_out, busy_out, result_valid_out, flags}, 8'd0);
    rst_n = 1'b1;
    step();

    run_word(4'b1000, 4'b1001, -1, 0, 1'b0, 0, e); to_idle(e);
    run_word(4'b0111, 4'b0110, 1, 2, 1'b0, 0, e);  to_idle(e);
    run_word(4'b1111, 4'b1111, -1, 0, 1'b0, 0, e); to_idle(e);
    run_word(4'b1100, 4'b0011, -1, 0, 1'b0, 3, e); to_idle(e);
    run_word(4'b0010, 4'b1110, -1, 0, 1'b0, 0, e);
    run_word(4'b0101, 4'b0100, -1, 0, 1'b0, 0, e); to_idle(e);

    // Abort after two beats; no result may appear.
    start_in = 1'b1; step(); start_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_bit_in = 1'b1; b_bit_in = 1'b0; bit_valid_in = 1'b1; step();
    end
    bit_valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {2'b00, bit_ready_out, busy_out, result_valid_out, flags}, 8'd0);
    step();
    rst_n = 1'b1;
    step();
    run_word(4'b0000, 4'b0000, -1, 0, 1'b0, 0, e); to_idle(e);

`ifdef DVSD_CMP_SIGNED_EN
    run_word(4'b1000, 4'b0111, -1, 0, 1'b1, 0, e); to_idle(e);
`endif
    run_word(4'b1000, 4'b0111, -1, 0, 1'b0, 0, e); to_idle(e);

    step();
    chk("sb_empty", 8'(sb_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
